// File: rtl/vector_rf_scheduler_pkg.sv
// Shared VRF write-side command codes, data-type codes and write-sequence FSM encodings
// for the vector register file scheduler.
package vector_rf_scheduler_pkg;

   localparam logic [1:0] RF_NOP          = 2'b00;
   localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
   localparam logic [1:0] RF_FINISHED     = 2'b10;

   localparam logic [2:0] ONE_BYTE   = 3'd0;
   localparam logic [2:0] TWO_BYTE   = 3'd1;
   localparam logic [2:0] FOUR_BYTE  = 3'd2;
   localparam logic [2:0] EIGHT_BYTE = 3'd3;

   localparam int NUM_VREGS = 32;
   localparam int REQ_ALU   = 0;
   localparam int REQ_LSU   = 1;

   typedef enum logic [1:0] {
      VRF_SCHED_IDLE  = 2'd0,
      VRF_SCHED_WRITE = 2'd1,
      VRF_SCHED_ACK   = 2'd2
   } vrf_sched_state_e;

endpackage

// File: rtl/vector_rf_scheduler_arbiter.sv
// Two-way one-hot write-back arbiter (requester 0 = ALU, 1 = LSU).
// VRF_SCHED_RR_ARB_EN selects round-robin; otherwise fixed priority with LSU first.
module vrf_wb_arbiter
   import vector_rf_scheduler_pkg::*;
(
`ifdef VRF_SCHED_RR_ARB_EN
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
`endif
   input  logic [1:0] req,
   output logic [1:0] gnt
);

`ifdef VRF_SCHED_RR_ARB_EN
   // Pointer names the requester that wins the next contested cycle.
   logic prefer_lsu;

   always_ff @(posedge clk) begin
      if (rst)
         prefer_lsu <= 1'b0;
      else if (advance)
         prefer_lsu <= gnt[REQ_ALU];
   end

   always_comb begin
      gnt = req;
      if (req == 2'b11)
         gnt = prefer_lsu ? 2'b10 : 2'b01;
   end
`else
   always_comb begin
      gnt = 2'b00;
      if (req[REQ_LSU])
         gnt = 2'b10;
      else if (req[REQ_ALU])
         gnt = 2'b01;
   end
`endif

endmodule

// File: rtl/vector_rf_scheduler.sv
// VRF front-end: pending-write scoreboard with RAW/WAW issue stall, and a
// three-state write sequence onto the single VRF write port. Macro: VRF_SCHED_RR_ARB_EN.
module vector_rf_scheduler
   import vector_rf_scheduler_pkg::*;
#(
   parameter  int LEN              = 32,
   parameter  int VECTOR_SIZE      = 8,
   parameter  int ENTRY_INDEX_SIZE = 3,
   localparam int VLEN             = VECTOR_SIZE * LEN,
   localparam int LW               = ENTRY_INDEX_SIZE + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy_in,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [4:0]           issue_rs1,
   input  logic [4:0]           issue_rs2,
   input  logic [4:0]           issue_rs3,
   input  logic [4:0]           issue_rd,
   input  logic [3:0]           issue_src_use,
   input  logic                 issue_writes_rd,
   input  logic [1:0]           wb_valid,
   output logic [1:0]           wb_ready,
   input  logic [9:0]           wb_rd,
   input  logic [2*VLEN-1:0]    wb_data,
   input  logic [2*VLEN-1:0]    wb_mask,
   input  logic [1:0]           wb_vm,
   input  logic [2*LW-1:0]      wb_length,
   input  logic [5:0]           wb_data_type,
   input  logic [1:0]           rf_status,
   output logic [1:0]           rf_signal,
   output logic [4:0]           rf_rd,
   output logic [VLEN-1:0]      rf_data,
   output logic [VLEN-1:0]      rf_mask,
   output logic                 rf_vm,
   output logic [LW-1:0]        rf_length,
   output logic [2:0]           rf_data_type,
   output logic                 rf_write_back_enabled,
   output logic [NUM_VREGS-1:0] pending
);

   vrf_sched_state_e     state, state_nxt;
   logic [1:0]           gnt;
   logic                 sel_lsu;
   logic                 hazard, issue_fire, grant_fire, wb_done;
   logic [NUM_VREGS-1:0] pending_nxt;

   vrf_wb_arbiter u_arb (
`ifdef VRF_SCHED_RR_ARB_EN
      .clk     (clk),
      .rst     (rst),
      .advance (grant_fire),
`endif
      .req     (wb_valid),
      .gnt     (gnt)
   );

   // v0 mask reads are checked against register 0.
   always_comb begin
      hazard = (issue_src_use[0] & pending[issue_rs1])
             | (issue_src_use[1] & pending[issue_rs2])
             | (issue_src_use[2] & pending[issue_rs3])
             | (issue_src_use[3] & pending[0])
             | (issue_writes_rd  & pending[issue_rd]);
   end

   assign issue_ready = ~hazard;
   assign issue_fire  = issue_valid & issue_ready & rdy_in;
   assign sel_lsu     = gnt[REQ_LSU];
   assign grant_fire  = (state == VRF_SCHED_IDLE) & rdy_in & (|gnt);
   assign wb_done     = (state == VRF_SCHED_ACK) & rdy_in & (rf_status == RF_FINISHED);

   always_ff @(posedge clk) begin
      if (rst)
         state <= VRF_SCHED_IDLE;
      else if (rdy_in)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         VRF_SCHED_IDLE:  if (|gnt) state_nxt = VRF_SCHED_WRITE;
         VRF_SCHED_WRITE: state_nxt = VRF_SCHED_ACK;
         VRF_SCHED_ACK:   if (rf_status == RF_FINISHED) state_nxt = VRF_SCHED_IDLE;
         default:         state_nxt = VRF_SCHED_IDLE;
      endcase
   end

   always_comb begin
      wb_ready              = 2'b00;
      rf_signal             = RF_NOP;
      rf_write_back_enabled = 1'b0;
      case (state)
         VRF_SCHED_IDLE:  if (rdy_in) wb_ready = gnt;
         VRF_SCHED_WRITE: begin
            rf_signal             = VECTOR_RF_WRITE;
            rf_write_back_enabled = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_rd        <= '0;
         rf_data      <= '0;
         rf_mask      <= '0;
         rf_vm        <= 1'b0;
         rf_length    <= '0;
         rf_data_type <= '0;
      end else if (grant_fire) begin
         rf_rd        <= sel_lsu ? wb_rd[9:5]                 : wb_rd[4:0];
         rf_data      <= sel_lsu ? wb_data[2*VLEN-1:VLEN]     : wb_data[VLEN-1:0];
         rf_mask      <= sel_lsu ? wb_mask[2*VLEN-1:VLEN]     : wb_mask[VLEN-1:0];
         rf_vm        <= sel_lsu ? wb_vm[1]                   : wb_vm[0];
         rf_length    <= sel_lsu ? wb_length[2*LW-1:LW]       : wb_length[LW-1:0];
         rf_data_type <= sel_lsu ? wb_data_type[5:3]          : wb_data_type[2:0];
      end
   end

   // A set and a clear never target the same index: WAW stalls the issue.
   always_comb begin
      pending_nxt = pending;
      if (wb_done)
         pending_nxt[rf_rd] = 1'b0;
      if (issue_fire && issue_writes_rd)
         pending_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: tb/tb_vector_rf_scheduler.sv
// Self-checking bench for vector_rf_scheduler: hazard table, write-back scoreboard,
// arbitration order, rdy_in freeze and mid-sequence reset.
module tb_vector_rf_scheduler;
   import vector_rf_scheduler_pkg::*;

   localparam int VLEN = 256;
   localparam int LW   = 4;

   logic              clk = 1'b0;
   logic              rst, rdy_in;
   logic              issue_valid, issue_ready, issue_writes_rd;
   logic [4:0]        issue_rs1, issue_rs2, issue_rs3, issue_rd;
   logic [3:0]        issue_src_use;
   logic [1:0]        wb_valid, wb_ready, wb_vm;
   logic [9:0]        wb_rd;
   logic [2*VLEN-1:0] wb_data, wb_mask;
   logic [2*LW-1:0]   wb_length;
   logic [5:0]        wb_data_type;
   logic [1:0]        rf_status, rf_signal;
   logic [4:0]        rf_rd;
   logic [VLEN-1:0]   rf_data, rf_mask;
   logic              rf_vm, rf_write_back_enabled;
   logic [LW-1:0]     rf_length;
   logic [2:0]        rf_data_type;
   logic [31:0]       pending;

   always #5 clk = ~clk;

   vector_rf_scheduler #(.LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3), .issue_rd(issue_rd),
      .issue_src_use(issue_src_use), .issue_writes_rd(issue_writes_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_mask(wb_mask), .wb_vm(wb_vm),
      .wb_length(wb_length), .wb_data_type(wb_data_type),
      .rf_status(rf_status), .rf_signal(rf_signal), .rf_rd(rf_rd),
      .rf_data(rf_data), .rf_mask(rf_mask), .rf_vm(rf_vm),
      .rf_length(rf_length), .rf_data_type(rf_data_type),
      .rf_write_back_enabled(rf_write_back_enabled), .pending(pending)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]      rd;
      logic [VLEN-1:0] data;
      logic [VLEN-1:0] mask;
      logic            vm;
      logic [LW-1:0]   len;
      logic [2:0]      dt;
   } wb_rec_t;

   typedef struct {
      logic [4:0] rs1, rs2, rs3, rd;
      logic [3:0] use_bits;
      logic       wr;
      logic       exp_ready;
   } haz_vec_t;

   wb_rec_t exp_q[$];

   task automatic check(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic wb_rec_t mk_rec(input int req, input logic [4:0] rd,
                                      input logic [LW-1:0] len, input logic [2:0] dt);
      wb_rec_t r;
      r.rd   = rd;
      r.data = {8{32'hA500_0000 | (32'(req) << 16) | 32'(rd)}};
      r.mask = {8{32'h0F0F_0000 ^ (32'(rd) << 4) ^ 32'(req)}};
      r.vm   = (req == 1);
      r.len  = len;
      r.dt   = dt;
      return r;
   endfunction

   task automatic drive_req(input int req, input wb_rec_t r);
      if (req == 0) begin
         wb_rd[4:0]             = r.rd;
         wb_data[VLEN-1:0]      = r.data;
         wb_mask[VLEN-1:0]      = r.mask;
         wb_vm[0]               = r.vm;
         wb_length[LW-1:0]      = r.len;
         wb_data_type[2:0]      = r.dt;
      end else begin
         wb_rd[9:5]             = r.rd;
         wb_data[2*VLEN-1:VLEN] = r.data;
         wb_mask[2*VLEN-1:VLEN] = r.mask;
         wb_vm[1]               = r.vm;
         wb_length[2*LW-1:LW]   = r.len;
         wb_data_type[5:3]      = r.dt;
      end
   endtask

   // Pops the oldest granted request and compares it to what the VRF sees in WRITE.
   task automatic expect_write(input string tag);
      wb_rec_t r;
      check({tag, ".wbe"}, VLEN'(rf_write_back_enabled), VLEN'(1'b1));
      check({tag, ".sig"}, VLEN'(rf_signal), VLEN'(VECTOR_RF_WRITE));
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.queue: got empty scoreboard expected one entry", tag);
      end else begin
         r = exp_q.pop_front();
         check({tag, ".rd"},   VLEN'(rf_rd), VLEN'(r.rd));
         check({tag, ".data"}, rf_data, r.data);
         check({tag, ".mask"}, rf_mask, r.mask);
         check({tag, ".vm"},   VLEN'(rf_vm), VLEN'(r.vm));
         check({tag, ".len"},  VLEN'(rf_length), VLEN'(r.len));
         check({tag, ".dt"},   VLEN'(rf_data_type), VLEN'(r.dt));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      haz_vec_t hv[10];
      wb_rec_t  r;
      wb_rec_t  alu_r[2];
      wb_rec_t  lsu_r[2];
      int       ai, li;
      logic     pref_lsu;
      logic [1:0] exp_g;

      rdy_in = 1'b1; issue_valid = 1'b0; issue_writes_rd = 1'b0;
      issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0; issue_rd = '0; issue_src_use = '0;
      wb_valid = '0; wb_rd = '0; wb_data = '0; wb_mask = '0; wb_vm = '0;
      wb_length = '0; wb_data_type = '0; rf_status = RF_NOP;
      do_reset();
      #1;
      check("rst.pending", VLEN'(pending), '0);
      check("rst.wb_ready", VLEN'(wb_ready), '0);
      check("rst.wbe", VLEN'(rf_write_back_enabled), '0);
      check("rst.rf_signal", VLEN'(rf_signal), VLEN'(RF_NOP));
      check("rst.rf_rd", VLEN'(rf_rd), '0);
      check("rst.rf_data", rf_data, '0);
      check("rst.issue_ready", VLEN'(issue_ready), VLEN'(1'b1));

      // Scoreboard set, then RAW stall on the same register.
      issue_valid = 1'b1; issue_rd = 5'd5; issue_writes_rd = 1'b1;
      #1 check("issue5.ready", VLEN'(issue_ready), VLEN'(1'b1));
      tick();
      issue_valid = 1'b0; issue_writes_rd = 1'b0;
      #1 check("issue5.pending", VLEN'(pending), VLEN'(32'h20));
      issue_valid = 1'b1; issue_rs1 = 5'd5; issue_src_use = 4'b0001;
      #1 check("raw5.ready", VLEN'(issue_ready), '0);
      tick();
      check("raw5.no_set", VLEN'(pending), VLEN'(32'h20));
      issue_src_use = 4'b0000; issue_writes_rd = 1'b1; issue_rd = 5'd0;
      tick();
      issue_rd = 5'd17;
      tick();
      issue_valid = 1'b0; issue_writes_rd = 1'b0;
      #1 check("pending3", VLEN'(pending), VLEN'(32'h0002_0021));

      hv[0] = '{5'd5,  5'd0,  5'd0,  5'd0,  4'b0001, 1'b0, 1'b0};
      hv[1] = '{5'd1,  5'd5,  5'd0,  5'd1,  4'b0010, 1'b0, 1'b0};
      hv[2] = '{5'd1,  5'd2,  5'd17, 5'd1,  4'b0100, 1'b0, 1'b0};
      hv[3] = '{5'd5,  5'd3,  5'd4,  5'd1,  4'b0110, 1'b0, 1'b1};
      hv[4] = '{5'd1,  5'd2,  5'd3,  5'd4,  4'b1000, 1'b0, 1'b0};
      hv[5] = '{5'd1,  5'd2,  5'd3,  5'd0,  4'b0000, 1'b1, 1'b0};
      hv[6] = '{5'd1,  5'd2,  5'd3,  5'd0,  4'b0000, 1'b0, 1'b1};
      hv[7] = '{5'd17, 5'd2,  5'd3,  5'd6,  4'b0000, 1'b1, 1'b1};
      hv[8] = '{5'd1,  5'd2,  5'd3,  5'd31, 4'b0001, 1'b1, 1'b1};
      hv[9] = '{5'd16, 5'd18, 5'd21, 5'd2,  4'b0111, 1'b1, 1'b1};
      for (int i = 0; i < 10; i++) begin
         issue_rs1 = hv[i].rs1; issue_rs2 = hv[i].rs2; issue_rs3 = hv[i].rs3;
         issue_rd = hv[i].rd; issue_src_use = hv[i].use_bits; issue_writes_rd = hv[i].wr;
         #1 check($sformatf("haz[%0d]", i), VLEN'(issue_ready), VLEN'(hv[i].exp_ready));
         tick();
      end
      check("haz.pending_kept", VLEN'(pending), VLEN'(32'h0002_0021));

      // ALU write-back of v5 releases the stalled reader.
      r = mk_rec(0, 5'd5, 4'd4, ONE_BYTE);
      drive_req(0, r);
      wb_valid = 2'b01;
      issue_valid = 1'b1; issue_rs1 = 5'd5; issue_src_use = 4'b0001;
      issue_rd = 5'd9; issue_writes_rd = 1'b0;
      #1 check("alu5.grant", VLEN'(wb_ready), VLEN'(2'b01));
      exp_q.push_back(r);
      check("alu5.stall", VLEN'(issue_ready), '0);
      tick();
      wb_valid = 2'b00;
      expect_write("alu5");
      tick();
      check("alu5.ack_wbe", VLEN'(rf_write_back_enabled), '0);
      check("alu5.ack_sig", VLEN'(rf_signal), VLEN'(RF_NOP));
      tick();
      check("alu5.ack_wait", VLEN'(pending), VLEN'(32'h0002_0021));
      rf_status = RF_FINISHED;
      tick();
      rf_status = RF_NOP;
      check("alu5.cleared", VLEN'(pending), VLEN'(32'h0002_0001));
      check("alu5.unstall", VLEN'(issue_ready), VLEN'(1'b1));
      tick();
      issue_valid = 1'b0; issue_src_use = 4'b0000;

      // Contested arbitration, three back-to-back write-backs.
      do_reset();
      alu_r[0] = mk_rec(0, 5'd10, 4'd8, FOUR_BYTE);
      alu_r[1] = mk_rec(0, 5'd11, 4'd2, TWO_BYTE);
      lsu_r[0] = mk_rec(1, 5'd20, 4'd8, EIGHT_BYTE);
      lsu_r[1] = mk_rec(1, 5'd21, 4'd1, ONE_BYTE);
      ai = 0; li = 0; pref_lsu = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wb_valid = {li < 2, ai < 2};
         if (ai < 2) drive_req(0, alu_r[ai]);
         if (li < 2) drive_req(1, lsu_r[li]);
`ifdef VRF_SCHED_RR_ARB_EN
         exp_g = (wb_valid == 2'b11) ? (pref_lsu ? 2'b10 : 2'b01) : wb_valid;
`else
         exp_g = wb_valid[1] ? 2'b10 : wb_valid;
`endif
         #1 check($sformatf("arb[%0d].grant", k), VLEN'(wb_ready), VLEN'(exp_g));
         if (exp_g[1]) begin
            exp_q.push_back(lsu_r[li]); li++; pref_lsu = 1'b0;
         end else begin
            exp_q.push_back(alu_r[ai]); ai++; pref_lsu = 1'b1;
         end
         tick();
         wb_valid = {li < 2, ai < 2};
         if (ai < 2) drive_req(0, alu_r[ai]);
         if (li < 2) drive_req(1, lsu_r[li]);
         #1;
         expect_write($sformatf("arb[%0d]", k));
         check($sformatf("arb[%0d].busy", k), VLEN'(wb_ready), '0);
         tick();
         rf_status = RF_FINISHED;
         #1 check($sformatf("arb[%0d].ack", k), VLEN'(rf_write_back_enabled), '0);
         tick();
         rf_status = RF_NOP;
      end
      wb_valid = 2'b00;

      // rdy_in low while in WRITE freezes everything.
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd7; issue_writes_rd = 1'b1; issue_src_use = 4'b0000;
      tick();
      issue_valid = 1'b0; issue_writes_rd = 1'b0;
      #1 check("frz.pending", VLEN'(pending), VLEN'(32'h80));
      r = mk_rec(1, 5'd7, 4'd3, TWO_BYTE);
      drive_req(1, r);
      wb_valid = 2'b10;
      #1 check("frz.grant", VLEN'(wb_ready), VLEN'(2'b10));
      exp_q.push_back(r);
      tick();
      wb_valid = 2'b00; rdy_in = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9; issue_writes_rd = 1'b1;
      rf_status = RF_FINISHED;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("frz[%0d].wbe", c), VLEN'(rf_write_back_enabled), VLEN'(1'b1));
         check($sformatf("frz[%0d].rd", c), VLEN'(rf_rd), VLEN'(5'd7));
         tick();
      end
      rdy_in = 1'b1; issue_valid = 1'b0; issue_writes_rd = 1'b0; rf_status = RF_NOP;
      #1 check("frz.no_issue", VLEN'(pending), VLEN'(32'h80));
      expect_write("frz");
      tick();
      check("frz.ack", VLEN'(rf_write_back_enabled), '0);
      rf_status = RF_FINISHED;
      tick();
      rf_status = RF_NOP;
      check("frz.cleared", VLEN'(pending), '0);

      // Reset while waiting in ACK drops the request.
      issue_valid = 1'b1; issue_rd = 5'd3; issue_writes_rd = 1'b1;
      tick();
      issue_valid = 1'b0; issue_writes_rd = 1'b0;
      r = mk_rec(0, 5'd3, 4'd4, ONE_BYTE);
      drive_req(0, r);
      wb_valid = 2'b01;
      #1 check("rstack.grant", VLEN'(wb_ready), VLEN'(2'b01));
      exp_q.push_back(r);
      tick();
      wb_valid = 2'b00;
      expect_write("rstack");
      tick();
      check("rstack.in_ack", VLEN'(pending), VLEN'(32'h8));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rstack.pending", VLEN'(pending), '0);
      check("rstack.rf_rd", VLEN'(rf_rd), '0);
      check("rstack.rf_data", rf_data, '0);
      check("rstack.rf_mask", rf_mask, '0);
      check("rstack.rf_len", VLEN'(rf_length), '0);
      check("rstack.rf_dt", VLEN'(rf_data_type), '0);
      check("rstack.rf_vm", VLEN'(rf_vm), '0);
      check("rstack.rf_sig", VLEN'(rf_signal), VLEN'(RF_NOP));
      check("rstack.wbe", VLEN'(rf_write_back_enabled), '0);
      wb_valid = 2'b01;
      #1 check("rstack.idle", VLEN'(wb_ready), VLEN'(2'b01));
      wb_valid = 2'b00;
      check("scoreboard.empty", VLEN'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
